// File: rtl/uart_core_param_if.sv
// Byte-stream side of the UART: TX handshake, RX show-ahead FIFO port and error pulses.
// master = DES control side, slave = uart_core_param.
interface uart_core_param_if #(
   parameter int DATA_BITS     = 8,
   parameter int RX_FIFO_DEPTH = 4
);
   localparam int CW = $clog2(RX_FIFO_DEPTH) + 1;

   logic                 tx_valid;
   logic [DATA_BITS-1:0] tx_data;
   logic                 tx_ready;
   logic                 rx_valid;
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_pop;
   logic [CW-1:0]        rx_count;
   logic                 frame_err;
   logic                 parity_err;
   logic                 overrun;

   modport master (
      output tx_valid, tx_data, rx_pop,
      input  tx_ready, rx_valid, rx_data, rx_count, frame_err, parity_err, overrun
   );
   modport slave (
      input  tx_valid, tx_data, rx_pop,
      output tx_ready, rx_valid, rx_data, rx_count, frame_err, parity_err, overrun
   );
endinterface

// File: rtl/uart_core_param.sv
// Parametrised UART TX/RX with show-ahead RX FIFO, framing/overrun detection.
// Define UART_PARITY_EN to add a parity bit (XOR(data) ^ PARITY_ODD) on both directions.
module uart_core_param #(
   parameter int CLKS_PER_BIT  = 10416,
   parameter int DATA_BITS     = 8,
   parameter int STOP_BITS     = 1,
   parameter int RX_FIFO_DEPTH = 4,
   parameter int PARITY_ODD    = 0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic rx_serial,
   output logic tx_serial,
   uart_core_param_if.slave bus
);
   localparam int AW = $clog2(RX_FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(STOP_BITS * CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [TW-1:0] BIT_END  = TW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] STOP_END = TW'(STOP_BITS * CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] HALF     = TW'((CLKS_PER_BIT - 1) / 2);
   localparam logic [BW-1:0] LAST     = BW'(DATA_BITS - 1);
`ifdef UART_PARITY_EN
   localparam logic PODD = PARITY_ODD[0];
`endif

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   // ---------------- TX ----------------
   state_t               tx_st;
   logic [TW-1:0]        tx_cnt;
   logic [BW-1:0]        tx_bit;
   logic [DATA_BITS-1:0] tx_shr;
`ifdef UART_PARITY_EN
   logic                 tx_par;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_st        <= S_IDLE;
         tx_cnt       <= '0;
         tx_bit       <= '0;
         tx_shr       <= '0;
         tx_serial    <= 1'b1;
         bus.tx_ready <= 1'b1;
`ifdef UART_PARITY_EN
         tx_par       <= 1'b0;
`endif
      end else begin
         tx_cnt <= tx_cnt + 1'b1;
         case (tx_st)
            S_IDLE: begin
               tx_cnt <= '0;
               if (bus.tx_valid) begin
                  tx_shr       <= bus.tx_data;
`ifdef UART_PARITY_EN
                  tx_par       <= (^bus.tx_data) ^ PODD;
`endif
                  tx_serial    <= 1'b0;
                  bus.tx_ready <= 1'b0;
                  tx_st        <= S_START;
               end
            end
            S_START: if (tx_cnt == BIT_END) begin
               tx_cnt    <= '0;
               tx_bit    <= '0;
               tx_serial <= tx_shr[0];
               tx_st     <= S_DATA;
            end
            S_DATA: if (tx_cnt == BIT_END) begin
               tx_cnt <= '0;
               tx_bit <= tx_bit + 1'b1;
               tx_shr <= tx_shr >> 1;
               if (tx_bit == LAST) begin
`ifdef UART_PARITY_EN
                  tx_serial <= tx_par;
                  tx_st     <= S_PARITY;
`else
                  tx_serial <= 1'b1;
                  tx_st     <= S_STOP;
`endif
               end else begin
                  tx_serial <= tx_shr[1];
               end
            end
`ifdef UART_PARITY_EN
            S_PARITY: if (tx_cnt == BIT_END) begin
               tx_cnt    <= '0;
               tx_serial <= 1'b1;
               tx_st     <= S_STOP;
            end
`endif
            S_STOP: if (tx_cnt == STOP_END) begin
               tx_st        <= S_IDLE;
               bus.tx_ready <= 1'b1;
            end
            default: tx_st <= S_IDLE;
         endcase
      end
   end

   // ---------------- RX ----------------
   logic                 rx_s1, rxs;
   state_t               rx_st;
   logic [TW-1:0]        rx_cnt;
   logic [BW-1:0]        rx_bit;
   logic [DATA_BITS-1:0] rx_shr;
`ifdef UART_PARITY_EN
   logic                 rx_par;
`endif

   logic [DATA_BITS-1:0] mem [RX_FIFO_DEPTH];
   logic [AW-1:0]        wptr, rptr, rptr_nx;
   logic [CW-1:0]        cnt;
   logic                 stop_hit, par_bad, good, full, pop, push, ovr;

   // Outcome of a stop-bit sample is decided here so the FIFO and pulses update on one edge.
   always_comb begin
      stop_hit = (rx_st == S_STOP) && (rx_cnt == BIT_END);
`ifdef UART_PARITY_EN
      par_bad  = rx_par ^ (^rx_shr) ^ PODD;
`else
      par_bad  = 1'b0;
`endif
      full     = (cnt == CW'(RX_FIFO_DEPTH));
      pop      = bus.rx_pop && (cnt != '0);
      good     = stop_hit && rxs && !par_bad;
      push     = good && (!full || pop);
      ovr      = good && full && !pop;
      rptr_nx  = rptr + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_s1          <= 1'b1;
         rxs            <= 1'b1;
         rx_st          <= S_IDLE;
         rx_cnt         <= '0;
         rx_bit         <= '0;
         rx_shr         <= '0;
         bus.frame_err  <= 1'b0;
         bus.parity_err <= 1'b0;
         bus.overrun    <= 1'b0;
`ifdef UART_PARITY_EN
         rx_par         <= 1'b0;
`endif
      end else begin
         rx_s1          <= rx_serial;
         rxs            <= rx_s1;
         bus.frame_err  <= stop_hit && !rxs;
         bus.parity_err <= stop_hit && rxs && par_bad;
         bus.overrun    <= ovr;
         rx_cnt         <= rx_cnt + 1'b1;
         case (rx_st)
            S_IDLE: begin
               rx_cnt <= '0;
               if (!rxs) rx_st <= S_START;
            end
            S_START: if (rx_cnt == HALF) begin
               rx_cnt <= '0;
               rx_bit <= '0;
               rx_st  <= rxs ? S_IDLE : S_DATA;
            end
            S_DATA: if (rx_cnt == BIT_END) begin
               rx_cnt <= '0;
               rx_shr <= {rxs, rx_shr[DATA_BITS-1:1]};
               rx_bit <= rx_bit + 1'b1;
`ifdef UART_PARITY_EN
               if (rx_bit == LAST) rx_st <= S_PARITY;
`else
               if (rx_bit == LAST) rx_st <= S_STOP;
`endif
            end
`ifdef UART_PARITY_EN
            S_PARITY: if (rx_cnt == BIT_END) begin
               rx_cnt <= '0;
               rx_par <= rxs;
               rx_st  <= S_STOP;
            end
`endif
            S_STOP: if (rx_cnt == BIT_END) rx_st <= S_IDLE;
            default: rx_st <= S_IDLE;
         endcase
      end
   end

   // ---------------- FIFO ----------------
   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= rx_shr;
   end

   // rx_data is a registered copy of the head so it can be reset and stays stable between pops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr        <= '0;
         rptr        <= '0;
         cnt         <= '0;
         bus.rx_data <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr_nx;
         if (push && !pop)      cnt <= cnt + 1'b1;
         else if (pop && !push) cnt <= cnt - 1'b1;
         if (push && ((cnt == '0) || (pop && cnt == CW'(1)))) bus.rx_data <= rx_shr;
         else if (pop && cnt > CW'(1))                         bus.rx_data <= mem[rptr_nx];
      end
   end

   assign bus.rx_valid = (cnt != '0);
   assign bus.rx_count = cnt;
endmodule

// File: tb/tb_uart_core_param.sv
// Scoreboard bench for uart_core_param: loopback and directly driven RX frames checked
// against a queue-based model of the FIFO and the expected per-frame outcome.
module tb_uart_core_param;
   localparam int CPB = 16, DB = 8, DEPTH = 4;
`ifdef UART_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif
   localparam int NBITS = 1 + DB + PB + 1;
   localparam int EV_PUSH = 0, EV_FRAME = 1, EV_PAR = 2, EV_OVR = 3;

   logic clk = 1'b0, rst_n = 1'b0, loop = 1'b1, rx_drv = 1'b1;
   logic rx_serial, tx_serial;
   always #5 clk = ~clk;
   assign rx_serial = loop ? tx_serial : rx_drv;

   uart_core_param_if #(.DATA_BITS(DB), .RX_FIFO_DEPTH(DEPTH)) bus ();

   uart_core_param #(
      .CLKS_PER_BIT(CPB), .DATA_BITS(DB), .STOP_BITS(1),
      .RX_FIFO_DEPTH(DEPTH), .PARITY_ODD(0)
   ) dut (
      .clk(clk), .rst_n(rst_n), .rx_serial(rx_serial), .tx_serial(tx_serial), .bus(bus)
   );

   int errors = 0, checks = 0;
   int exp_q[$];
   logic [7:0] data_q[$];

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Model: what a frame must produce, judged against the FIFO contents known at issue time.
   function automatic void expect_frame(logic [7:0] d, bit stop_ok, bit par_ok);
      if (!stop_ok)                    exp_q.push_back(EV_FRAME);
      else if (PB == 1 && !par_ok)     exp_q.push_back(EV_PAR);
      else if (data_q.size() == DEPTH) exp_q.push_back(EV_OVR);
      else begin
         exp_q.push_back(EV_PUSH);
         data_q.push_back(d);
      end
   endfunction

   function automatic logic exp_bit(logic [7:0] d, int k);
      if (k == 0) return 1'b0;
      if (k <= DB) return d[k-1];
      if (PB == 1 && k == DB + 1) return ^d;
      return 1'b1;
   endfunction

   // Monitor: every output event pops the next expected outcome; every pop checks the head.
   initial begin : monitor
      int prev, ev, e;
      logic [7:0] d;
      prev = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev = 0;
            continue;
         end
         if (bus.rx_pop && bus.rx_valid) begin
            if (data_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL rx_pop_data: popped %0h with nothing expected", bus.rx_data);
            end else begin
               d = data_q.pop_front();
               chk("rx_pop_data", bus.rx_data, d);
            end
         end
         ev = -1;
         if (bus.frame_err)                ev = EV_FRAME;
         else if (bus.parity_err)          ev = EV_PAR;
         else if (bus.overrun)             ev = EV_OVR;
         else if (int'(bus.rx_count) > prev) ev = EV_PUSH;
         if (ev >= 0) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL rx_event: got event %0d expected none", ev);
            end else begin
               e = exp_q.pop_front();
               chk("rx_event", ev, e);
            end
         end
         prev = int'(bus.rx_count);
      end
   end

   task automatic wait_events();
      for (int i = 0; i < 80 && exp_q.size() != 0; i++) @(negedge clk);
      chk("events_drained", exp_q.size(), 0);
   endtask

   task automatic check_count(string tag);
      chk({tag, "_rx_count"}, bus.rx_count, data_q.size());
      chk({tag, "_rx_valid"}, bus.rx_valid, data_q.size() != 0);
   endtask

   // Entered and left on a negedge; leaves tx_ready high so calls chain back-to-back.
   task automatic tx_frame(logic [7:0] d);
      logic line [200];
      int low;
      bit done;
      low = 0; done = 0;
      for (int i = 0; i < 400 && !bus.tx_ready; i++) @(negedge clk);
      chk("tx_ready_before", bus.tx_ready, 1);
      expect_frame(d, 1'b1, 1'b1);
      bus.tx_valid = 1'b1;
      bus.tx_data  = d;
      @(posedge clk);
      #1 bus.tx_valid = 1'b0;
      bus.tx_data = 8'($urandom);
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         line[i] = tx_serial;
         if (bus.tx_ready) done = 1'b1;
         else low++;
      end
      chk("tx_ready_low_cycles", low, NBITS * CPB);
      for (int k = 0; k < NBITS; k++)
         chk($sformatf("tx_bit%0d_of_%0h", k, d), line[k*CPB + CPB/2], exp_bit(d, k));
   endtask

   task automatic rx_inject(logic [7:0] d, bit stop_ok, bit par_ok);
      logic bits[$];
      loop = 1'b0;
      expect_frame(d, stop_ok, par_ok);
      bits.push_back(1'b0);
      for (int i = 0; i < DB; i++) bits.push_back(d[i]);
      if (PB == 1) bits.push_back((^d) ^ !par_ok);
      foreach (bits[i]) begin
         rx_drv = bits[i];
         repeat (CPB) @(negedge clk);
      end
      // A bad stop bit is released a few cycles early so the line is clearly idle afterwards.
      rx_drv = stop_ok;
      repeat (stop_ok ? CPB : 13) @(negedge clk);
      rx_drv = 1'b1;
      repeat (CPB) @(negedge clk);
      wait_events();
      loop = 1'b1;
   endtask

   task automatic pop_one();
      @(posedge clk);
      #1 bus.rx_pop = 1'b1;
      @(posedge clk);
      #1 bus.rx_pop = 1'b0;
      @(negedge clk);
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int r;
      bus.tx_valid = 1'b0;
      bus.tx_data  = '0;
      bus.rx_pop   = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_tx_serial", tx_serial, 1);
      chk("rst_tx_ready", bus.tx_ready, 1);
      chk("rst_rx_valid", bus.rx_valid, 0);
      chk("rst_rx_data", bus.rx_data, 0);
      chk("rst_rx_count", bus.rx_count, 0);
      chk("rst_err_pulses", {bus.frame_err, bus.parity_err, bus.overrun}, 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      pop_one();
      check_count("empty_pop");

      tx_frame(8'hA5);
      wait_events();
      check_count("a5");
      pop_one();
      check_count("a5_popped");

      tx_frame(8'h31); tx_frame(8'h32); tx_frame(8'h33);
      wait_events();
      check_count("three");
      repeat (3) pop_one();
      check_count("three_drained");

      for (int i = 0; i < 5; i++) tx_frame(8'(i));
      wait_events();
      check_count("overrun");
      repeat (4) pop_one();
      check_count("overrun_drained");

      rx_inject(8'h55, 1'b0, 1'b1);
      check_count("frame_err");

`ifdef UART_PARITY_EN
      rx_inject(8'h07, 1'b1, 1'b0);
      check_count("parity_bad");
      rx_inject(8'h07, 1'b1, 1'b1);
      check_count("parity_good");
`endif

      for (int it = 0; it < 24; it++) begin
         r = $urandom_range(0, 3);
         case (r)
            0: tx_frame(8'($urandom));
            1: rx_inject(8'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
            default: if (data_q.size() != 0) pop_one(); else tx_frame(8'($urandom));
         endcase
         wait_events();
         check_count($sformatf("rand%0d", it));
      end

      while (data_q.size() > 2) pop_one();
      while (data_q.size() < 2) begin
         tx_frame(8'($urandom));
         wait_events();
      end
      check_count("pre_reset");

      // Reset during bit 3 of 0x5A, where the line is low.
      bus.tx_valid = 1'b1;
      bus.tx_data  = 8'h5A;
      @(posedge clk);
      #1 bus.tx_valid = 1'b0;
      repeat (3 * CPB + 7) @(posedge clk);
      #1 chk("tx_mid_data_low", tx_serial, 0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_tx_serial", tx_serial, 1);
      chk("mid_rst_tx_ready", bus.tx_ready, 1);
      chk("mid_rst_rx_count", bus.rx_count, 0);
      chk("mid_rst_rx_valid", bus.rx_valid, 0);
      data_q.delete();
      exp_q.delete();
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      check_count("post_reset");
      tx_frame(8'h41);
      wait_events();
      check_count("post_reset_41");
      pop_one();
      check_count("final");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
